column_select_rx: RTL and testbench

//  Receive end of the column-select serial link (ser_clk/ser_data/ser_stcp/ser_n_enable); 74HC595 emulation in fabric.

---
 rtl/output_module_rx_pkg.sv | 6 +
 rtl/sync_edge_detect.sv | 28 ++
 rtl/column_select_rx.sv | 116 +++++++++++
 tb/tb_column_select_rx.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/output_module_rx_pkg.sv
// Shared types and bit positions for the column-select serial receiver.
package output_module_rx_pkg;
  typedef enum logic [1:0] {S0_WARMUP, S1_IDLE, S2_SHIFT, S3_LATCH} state_t;
  localparam int COL_SELECT_BIT = 0;
  localparam int EXTRA_BIT_POS  = 1;
endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one async wire with a registered rising-edge pulse.
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise
);
  logic [STAGES-1:0] stages;
  logic              prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      stages <= {STAGES{RESET_VAL}};
      prev   <= RESET_VAL;
      rise   <= 1'b0;
    end else begin
      stages <= {stages[STAGES-2:0], din};
      prev   <= stages[STAGES-1];
      rise   <= stages[STAGES-1] & ~prev;
    end
  end

  assign sync = stages[STAGES-1];
endmodule

// File: rtl/column_select_rx.sv
// 74HC595-style receiver: oversampled shift/latch of the column-select link,
// plus column tracking and bit-count checking on every latch.
module column_select_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int NUM_COLUMNS = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ser_clk,
  input  logic                           ser_data,
  input  logic                           ser_stcp,
  input  logic                           ser_n_enable,
  output logic [WIDTH-1:0]               q_parallel,
  output logic                           q_valid,
  output logic                           extra_bit,
  output logic [$clog2(NUM_COLUMNS)-1:0] col_index,
  output logic                           frame_start,
  output logic                           col_overflow,
  output logic                           bit_count_error,
  output logic                           outputs_enabled
);
  import output_module_rx_pkg::*;

  localparam int CNT_W  = $clog2(WIDTH) + 2;
  localparam int COL_W  = $clog2(NUM_COLUMNS);
  localparam int WARM_W = $clog2(SYNC_STAGES + 2) + 1;
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(2 * WIDTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(WIDTH);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(NUM_COLUMNS - 1);

  logic clk_rise, stcp_rise, data_sync, nen_sync;
  logic clk_sync_unused, stcp_sync_unused, data_rise_unused, nen_rise_unused;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst(rst), .din(ser_clk), .sync(clk_sync_unused), .rise(clk_rise));
  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_data (
    .clk(clk), .rst(rst), .din(ser_data), .sync(data_sync), .rise(data_rise_unused));
  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_stcp (
    .clk(clk), .rst(rst), .din(ser_stcp), .sync(stcp_sync_unused), .rise(stcp_rise));
  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nen (
    .clk(clk), .rst(rst), .din(ser_n_enable), .sync(nen_sync), .rise(nen_rise_unused));

  state_t            state;
  logic [WARM_W-1:0] warm_cnt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [WIDTH-1:0]  shift_reg;
  logic              pend_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S0_WARMUP;
      warm_cnt        <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      pend_shift      <= 1'b0;
      q_parallel      <= '0;
      col_index       <= '0;
      q_valid         <= 1'b0;
      frame_start     <= 1'b0;
      col_overflow    <= 1'b0;
      bit_count_error <= 1'b0;
      outputs_enabled <= 1'b0;
    end else begin
      q_valid         <= 1'b0;
      frame_start     <= 1'b0;
      col_overflow    <= 1'b0;
      bit_count_error <= 1'b0;
      outputs_enabled <= ~nen_sync;
      case (state)
        // Lines held high across reset produce one rise pulse; swallow it here.
        S0_WARMUP: begin
          if (warm_cnt == WARM_LAST) state <= S1_IDLE;
          else warm_cnt <= warm_cnt + 1'b1;
        end
        S1_IDLE, S2_SHIFT: begin
          if (stcp_rise) begin
            // A coincident shift is deferred so the latch sees pre-shift contents.
            state      <= S3_LATCH;
            pend_shift <= clk_rise;
          end else if (clk_rise) begin
            shift_reg <= {shift_reg[WIDTH-2:0], data_sync};
            if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 1'b1;
            state <= S2_SHIFT;
          end
        end
        S3_LATCH: begin
          q_parallel      <= shift_reg;
          q_valid         <= 1'b1;
          bit_count_error <= (bit_cnt != CNT_FULL);
          pend_shift      <= 1'b0;
          if (!shift_reg[COL_SELECT_BIT]) begin
            col_index   <= '0;
            frame_start <= 1'b1;
          end else if (col_index == COL_LAST) begin
            col_overflow <= 1'b1;
          end else begin
            col_index <= col_index + 1'b1;
          end
          if (clk_rise || pend_shift) begin
            shift_reg <= {shift_reg[WIDTH-2:0], data_sync};
            bit_cnt   <= CNT_W'(1);
            state     <= S2_SHIFT;
          end else begin
            bit_cnt <= '0;
            state   <= S1_IDLE;
          end
        end
        default: state <= S0_WARMUP;
      endcase
    end
  end

  assign extra_bit = q_parallel[EXTRA_BIT_POS];
endmodule

// File: tb/tb_column_select_rx.sv
// Directed bench for column_select_rx: link timing driven on negedges, outputs sampled on negedges.
module tb_column_select_rx;
  localparam int WIDTH = 8;
  localparam int SS    = 2;
  localparam int NC    = 16;
  localparam int P     = 4;

  logic       clk = 1'b0;
  logic       rst, ser_clk, ser_data, ser_stcp, ser_n_enable;
  logic [7:0] q_parallel;
  logic       q_valid, extra_bit, frame_start, col_overflow, bit_count_error, outputs_enabled;
  logic [3:0] col_index;

  int         checks = 0;
  int         fails  = 0;
  int         lat;
  int         pulses;
  logic [7:0] cq;
  logic [3:0] ccol;
  logic       cx, cfs, cov, cerr;

  always #5 clk = ~clk;

  column_select_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SS), .NUM_COLUMNS(NC)) dut (
    .clk(clk), .rst(rst), .ser_clk(ser_clk), .ser_data(ser_data), .ser_stcp(ser_stcp),
    .ser_n_enable(ser_n_enable), .q_parallel(q_parallel), .q_valid(q_valid),
    .extra_bit(extra_bit), .col_index(col_index), .frame_start(frame_start),
    .col_overflow(col_overflow), .bit_count_error(bit_count_error),
    .outputs_enabled(outputs_enabled));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ser_data = v[i];
      ser_clk  = 1'b0;
      repeat (P) @(negedge clk);
      ser_clk = 1'b1;
      repeat (P) @(negedge clk);
    end
    ser_clk = 1'b0;
  endtask

  // Raise stcp, wait (bounded) for the q_valid pulse and capture the outputs in that cycle.
  task automatic do_latch();
    int n = 0;
    ser_stcp = 1'b1;
    lat = -1;
    while (n < 20 && lat < 0) begin
      @(negedge clk);
      n++;
      if (q_valid) begin
        lat = n - 1; cq = q_parallel; cx = extra_bit; cfs = frame_start;
        cov = col_overflow; cerr = bit_count_error; ccol = col_index;
      end
    end
    check("q_valid_seen", (lat >= 0), 1);
    ser_stcp = 1'b0;
    repeat (P) @(negedge clk);
  endtask

  task automatic count_pulses(input int n);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (q_valid || frame_start || col_overflow || bit_count_error) pulses++;
    end
  endtask

  initial begin
    rst = 1'b1; ser_clk = 1'b1; ser_data = 1'b0; ser_stcp = 1'b0; ser_n_enable = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    count_pulses(10);
    check("rst_no_pulse", pulses, 0);
    check("rst_q", q_parallel, 8'h00);
    check("rst_col", col_index, 0);
    check("rst_oe", outputs_enabled, 0);
    check("rst_extra", extra_bit, 0);
    ser_clk = 1'b0;
    repeat (P) @(negedge clk);

    // 8'h02: first column, extra bit set; also proves no shift from ser_clk high at reset
    send_bits(16'h02, 8);
    do_latch();
    check("t2_latency", lat, SS + 2);
    check("t2_q", cq, 8'h02);
    check("t2_extra", cx, 1);
    check("t2_fs", cfs, 1);
    check("t2_col", ccol, 0);
    check("t2_err", cerr, 0);

    for (int k = 1; k <= 15; k++) begin
      send_bits(16'h01, 8);
      do_latch();
      check("t3_col", ccol, k);
      check("t3_ovf", cov, 0);
      check("t3_fs", cfs, 0);
    end
    send_bits(16'h01, 8);
    do_latch();
    check("t3_ovf_last", cov, 1);
    check("t3_col_sat", ccol, 15);
    check("t3_extra", cx, 0);

    // 01 shifted left by 5 bits of 10110 -> 8'h36 (shift register not cleared by latch)
    send_bits(16'h16, 5);
    do_latch();
    check("t4_short_err", cerr, 1);
    check("t4_short_q", cq, 8'h36);
    check("t4_short_col", ccol, 0);
    send_bits(16'h155, 9);
    do_latch();
    check("t4_long_err", cerr, 1);
    check("t4_long_q", cq, 8'h55);
    check("t4_long_col", ccol, 1);

    // A5 then coincident ser_clk/ser_stcp rise with data 0
    send_bits(16'hA5, 8);
    ser_data = 1'b0;
    repeat (P) @(negedge clk);
    ser_clk = 1'b1;
    do_latch();
    check("t5_q", cq, 8'hA5);
    check("t5_err", cerr, 0);
    check("t5_col", ccol, 2);
    send_bits(16'h55, 7);
    do_latch();
    check("t5_next_q", cq, 8'h55);
    check("t5_next_err", cerr, 0);
    check("t5_next_col", ccol, 3);

    send_bits(16'h0F, 4);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    count_pulses(10);
    check("t6_no_pulse", pulses, 0);
    check("t6_q_rst", q_parallel, 8'h00);
    check("t6_col_rst", col_index, 0);
    send_bits(16'h00, 8);
    do_latch();
    check("t6_q", cq, 8'h00);
    check("t6_err", cerr, 0);
    check("t6_fs", cfs, 1);

    ser_n_enable = 1'b0;
    repeat (SS) @(negedge clk);
    check("t6_oe_early", outputs_enabled, 0);
    @(negedge clk);
    check("t6_oe", outputs_enabled, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
